prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Streams bytes from a valid/ready source into a simple synchronous memory,
// starting at base_addr and continuing for length bytes. Each accepted byte
// gets one WRITE cycle. With the optional read-back feature, the byte is also
// read back for one VERIFY cycle and compared against what was written.
//
// Optional feature macro: PROG_LOADER_VERIFY_EN
//   defined   : VERIFY state and the sticky error output exist; every byte is
//               read back one cycle after its write.
//   undefined : no VERIFY state, no error port, mem_read is tied to 0.
//
// Handshake: a stream byte transfers on a posedge where in_valid and in_ready
// are both high. in_ready depends only on the FSM state, never on in_valid,
// and the source must hold in_data stable while in_valid is high and
// in_ready is low.
//
// Ports
//   clk          in   single clock, all state updates on posedge
//   rst_n        in   synchronous active-low reset
//   start        in   load request, only honoured in IDLE
//   base_addr    in   first memory address of the load
//   length       in   byte count; 0 means the full 2^ADDR_W locations
//   in_valid     in   stream byte present
//   in_data      in   stream byte
//   in_ready     out  loader can accept a stream byte (WAIT only)
//   mem_write    out  memory write strobe, captured by memory on next posedge
//   mem_read     out  memory read enable, read_data returns combinationally
//   access_addr  out  memory address
//   write_data   out  memory write data
//   read_data    in   memory read data
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse at the end of a load
//   error        out  sticky read-back mismatch (PROG_LOADER_VERIFY_EN only)
//   dbg_state    out  current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] access_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done,
`ifdef PROG_LOADER_VERIFY_EN
    output logic              error,
`endif
    output logic [2:0]        dbg_state
);

    // FSM encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
`ifdef PROG_LOADER_VERIFY_EN
    localparam logic [2:0] S_VERIFY = 3'd3;
`endif
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_FULL = {1'b1, {ADDR_W{1'b0}}};

    // State and datapath registers
    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0] data_q,      data_d;
`ifdef PROG_LOADER_VERIFY_EN
    logic              error_q,     error_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
`ifdef PROG_LOADER_VERIFY_EN
        error_d     = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    // A zero length means the whole address space; the extra
                    // counter bit lets us represent 2^ADDR_W exactly.
                    remaining_d = (length == '0) ? REM_FULL : {1'b0, length};
`ifdef PROG_LOADER_VERIFY_EN
                    error_d = 1'b0;
`endif
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                // Address wraps naturally at 2^ADDR_W.
                addr_d      = addr_q + ADDR_ONE;
                remaining_d = remaining_q - REM_ONE;
`ifdef PROG_LOADER_VERIFY_EN
                state_d = S_VERIFY;
`else
                // remaining_q still counts the byte being written now.
                state_d = (remaining_q == REM_ONE) ? S_DONE : S_WAIT;
`endif
            end

`ifdef PROG_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (read_data != data_q) begin
                    error_d = 1'b1;
                end
                // Counter was already decremented when WRITE was left.
                state_d = (remaining_q == '0) ? S_DONE : S_WAIT;
            end
`endif

            S_DONE: begin
                // start is deliberately not looked at here.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers (synchronous active-low reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
`ifdef PROG_LOADER_VERIFY_EN
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
`ifdef PROG_LOADER_VERIFY_EN
            error_q     <= error_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded only from state and registers
    // -------------------------------------------------------------------------
    assign in_ready   = (state_q == S_WAIT);
    assign mem_write  = (state_q == S_WRITE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign write_data = (state_q == S_WRITE) ? data_q : '0;
    assign dbg_state  = state_q;

`ifdef PROG_LOADER_VERIFY_EN
    assign mem_read = (state_q == S_VERIFY);
    assign error    = error_q;

    // In VERIFY the address register has already advanced past the byte
    // just written, so step back one to read that same location.
    always_comb begin
        access_addr = '0;
        if (state_q == S_WRITE) begin
            access_addr = addr_q;
        end else if (state_q == S_VERIFY) begin
            access_addr = addr_q - ADDR_ONE;
        end
    end
`else
    assign mem_read    = 1'b0;
    assign access_addr = (state_q == S_WRITE) ? addr_q : '0;

    // read_data has no consumer without the read-back feature.
    logic unused_read_data;
    assign unused_read_data = ^read_data;
`endif

endmodule
